// File: rtl/types_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
// Shared sizes and types for the rename-stage free list.
//   NUM_PREGS  : physical registers (7-bit preg ids)
//   NUM_AREGS  : architectural registers; pregs 0..NUM_AREGS-1 are mapped at reset
//   ROB_DEPTH  : checkpoint slots, one per ROB tag
//   INIT_FREE  : pregs free after reset (NUM_PREGS - NUM_AREGS)
// -----------------------------------------------------------------------------
package types_pkg;

  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;
  localparam int ROB_DEPTH = 16;
  localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

  typedef logic [6:0] preg_t;
  typedef logic [4:0] rob_tag_t;
  typedef logic [7:0] fl_ptr_t;
  typedef logic [3:0] ckpt_idx_t;

endpackage

// File: rtl/free_list_ckpt.sv
// -----------------------------------------------------------------------------
// free_list_ckpt
// Per-ROB-tag snapshot of the free-list read pointer. ROB_DEPTH x 8-bit
// register file, one synchronous write port, one asynchronous read port.
// All slots clear to 0 on reset.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   wr_en_i     : write slot wr_idx_i with wr_data_i at the clock edge
//   wr_idx_i    : write slot index
//   wr_data_i   : read pointer to store
//   rd_idx_i    : read slot index
//   rd_data_o   : stored read pointer (combinational)
// -----------------------------------------------------------------------------
module free_list_ckpt
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic [3:0] wr_idx_i,
  input  logic [7:0] wr_data_i,
  input  logic [3:0] rd_idx_i,
  output logic [7:0] rd_data_o
);

  logic [7:0] ckpt_q [ROB_DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        ckpt_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      ckpt_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = ckpt_q[rd_idx_i];

endmodule

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Physical-register free list for the rename stage. A circular FIFO of
// NUM_PREGS preg ids: rename pops the head, ROB retire pushes preg_old back,
// and a mispredict rewinds the read pointer to the checkpoint taken when the
// branch's ROB tag was allocated.
//
// Optional feature (macro FREE_LIST_BYPASS_EN): when the list is empty and a
// retire frees a preg in the same cycle, that preg is offered on preg_new
// immediately, and a pop in that cycle takes it without touching storage.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   pop_en          : rename consumes the head preg this cycle
//   preg_new        : head preg offered to rename
//   preg_valid      : preg_new is valid
//   rob_write_en    : ROB allocation this cycle (takes a checkpoint)
//   rob_tag         : ROB tag being allocated
//   valid_retired   : retire pulse; preg_old is returned to the list
//   preg_old        : preg freed by retire (preg 0 is never freed)
//   mispredict      : rewind read pointer to checkpoint of mispredict_tag
//   mispredict_tag  : tag of the mispredicted branch
//   empty           : no free pregs
//   count           : number of free pregs
//   overflow_err    : sticky; a push arrived while count was NUM_PREGS-NUM_AREGS
// -----------------------------------------------------------------------------
module free_list
  import types_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pop_en,
  output logic [6:0] preg_new,
  output logic       preg_valid,
  input  logic       rob_write_en,
  input  logic [4:0] rob_tag,
  input  logic       valid_retired,
  input  logic [6:0] preg_old,
  input  logic       mispredict,
  input  logic [4:0] mispredict_tag,
  output logic       empty,
  output logic [7:0] count,
  output logic       overflow_err
);

  // Handshake: preg_valid is the offer, pop_en is the take. A preg is
  // consumed only on a cycle where both are high and no mispredict is
  // flushing; pop_en while preg_valid is low is ignored without error.

  logic [6:0] mem_q [NUM_PREGS];
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic [7:0] wr_ptr_q, wr_ptr_d;
  logic [7:0] rd_ptr_adv;
  logic [7:0] ckpt_rd_data;
  logic [7:0] count_w;
  logic       empty_w;
  logic       push_req;
  logic       bypass_hit;
  logic       bypass_take;
  logic       pop_fire;
  logic       push_fire;
  logic       ckpt_wr_en;
  logic       overflow_q;
  logic       unused_tag_msbs;

  // Only the low 4 tag bits select a checkpoint slot.
  assign unused_tag_msbs = rob_tag[4] ^ mispredict_tag[4];

  // Pointers carry a wrap bit, so the 8-bit difference is the free count.
  assign count_w  = wr_ptr_q - rd_ptr_q;
  assign empty_w  = (count_w == 8'd0);
  assign push_req = valid_retired && (preg_old != '0);

`ifdef FREE_LIST_BYPASS_EN
  assign bypass_hit = empty_w && push_req;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed preg handed straight to rename never enters storage.
  assign bypass_take = bypass_hit && pop_en && !mispredict;
  assign pop_fire    = pop_en && !empty_w && !mispredict;
  assign push_fire   = push_req && !bypass_take;

  // Checkpoint holds the pointer after this cycle's pop so the branch's own
  // destination stays allocated after recovery.
  assign rd_ptr_adv = rd_ptr_q + {7'd0, pop_fire};
  assign ckpt_wr_en = rob_write_en && !mispredict;

  free_list_ckpt u_ckpt (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ckpt_wr_en),
    .wr_idx_i  (rob_tag[3:0]),
    .wr_data_i (rd_ptr_adv),
    .rd_idx_i  (mispredict_tag[3:0]),
    .rd_data_o (ckpt_rd_data)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_adv;
    wr_ptr_d = wr_ptr_q + {7'd0, push_fire};
    // Recovery frees flushed pops by rewinding; the write side is untouched.
    if (mispredict) begin
      rd_ptr_d = ckpt_rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= 8'(INIT_FREE);
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (push_req && (count_w == 8'(INIT_FREE))) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage: entries 0..INIT_FREE-1 start out holding the unmapped pregs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        mem_q[i] <= (i < INIT_FREE) ? preg_t'(i + NUM_AREGS) : '0;
      end
    end else if (push_fire) begin
      mem_q[wr_ptr_q[6:0]] <= preg_old;
    end
  end

  assign preg_new     = bypass_hit ? preg_old : mem_q[rd_ptr_q[6:0]];
  assign preg_valid   = bypass_hit || !empty_w;
  assign empty        = empty_w;
  assign count        = count_w;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
// Scoreboard bench for free_list. The driver applies one set of inputs per
// cycle at the falling edge, derives the expected outputs for that cycle from
// a reference model (a preg array indexed by unbounded head/tail counts, with
// checkpoints stored as head counts), and queues them. A monitor pops and
// compares a little after the falling edge. Directed checks follow the
// scenarios of interest; a randomized phase follows. Honors FREE_LIST_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pop_en = 1'b0;
  logic [6:0] preg_new;
  logic       preg_valid;
  logic       rob_write_en = 1'b0;
  logic [4:0] rob_tag = '0;
  logic       valid_retired = 1'b0;
  logic [6:0] preg_old = '0;
  logic       mispredict = 1'b0;
  logic [4:0] mispredict_tag = '0;
  logic       empty;
  logic [7:0] count;
  logic       overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  // {preg[17:11], valid[10], count[9:2], empty[1], overflow[0]}
  logic [17:0] exp_q[$];

  // Reference model
  int         m_head, m_tail;
  logic [6:0] m_mem [128];
  int         m_ckpt [16];
  bit         m_ck_ok [16];
  bit         m_ovf;

  free_list dut (
    .clk            (clk),
    .reset          (reset),
    .pop_en         (pop_en),
    .preg_new       (preg_new),
    .preg_valid     (preg_valid),
    .rob_write_en   (rob_write_en),
    .rob_tag        (rob_tag),
    .valid_retired  (valid_retired),
    .preg_old       (preg_old),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .empty          (empty),
    .count          (count),
    .overflow_err   (overflow_err)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    #2;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_preg_valid", int'(preg_valid), int'(e[10]));
      chk("sb_count", int'(count), int'(e[9:2]));
      chk("sb_empty", int'(empty), int'(e[1]));
      chk("sb_overflow", int'(overflow_err), int'(e[0]));
      if (e[10]) chk("sb_preg_new", int'(preg_new), int'(e[17:11]));
    end
  end

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = (i < 96) ? 7'(i + 32) : 7'd0;
    for (int i = 0; i < 16; i++) begin
      m_ckpt[i]  = 0;
      m_ck_ok[i] = 1'b0;
    end
    m_head = 0;
    m_tail = 96;
    m_ovf  = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Called right after a falling edge: drives inputs, queues the expected
  // outputs for this cycle, advances the model to the next cycle.
  task automatic apply(input bit pop, input bit vr, input logic [6:0] po,
                       input bit mp, input int mpt, input bit we, input int tag);
    int         cnt, nh;
    bit         emp, byp, take, e_vld;
    logic [6:0] e_preg;
    logic [7:0] c8;
    pop_en         = pop;
    valid_retired  = vr;
    preg_old       = po;
    mispredict     = mp;
    mispredict_tag = 5'(mpt);
    rob_write_en   = we;
    rob_tag        = 5'(tag);

    cnt = m_tail - m_head;
    emp = (cnt == 0);
    byp = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
    byp = emp && vr && (po != 0);
`endif
    e_vld  = byp || !emp;
    e_preg = byp ? po : m_mem[m_head % 128];
    c8     = 8'(cnt);
    exp_q.push_back({e_preg, e_vld, c8, emp, m_ovf});

    take = byp && pop && !mp;
    nh   = m_head + ((pop && !mp && !emp) ? 1 : 0);
    if (we && !mp) begin
      m_ckpt[tag % 16]  = nh;
      m_ck_ok[tag % 16] = 1'b1;
    end
    if (vr && po != 0 && cnt == 96) m_ovf = 1'b1;
    if (vr && po != 0 && !take) begin
      m_mem[m_tail % 128] = po;
      m_tail++;
    end
    m_head = mp ? m_ckpt[mpt % 16] : nh;
  endtask

  task automatic idle();
    apply(0, 0, 7'd0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pop_en = 0; valid_retired = 0; preg_old = 0;
    mispredict = 0; mispredict_tag = 0; rob_write_en = 0; rob_tag = 0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // reset state
    idle(); #3;
    chk("rst_preg_new", int'(preg_new), 32);
    chk("rst_count", int'(count), 96);
    chk("rst_empty", int'(empty), 0);
    chk("rst_valid", int'(preg_valid), 1);
    chk("rst_overflow", int'(overflow_err), 0);
    step();

    // three pops: 32, 33, 34
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 7'd0, 0, 0, 0, 0); #3;
      chk("pop_seq", int'(preg_new), 32 + i);
      step();
    end
    idle(); #3;
    chk("pop3_count", int'(count), 93);
    step();

    // retire 0x10 then preg 0: only one push counts
    apply(0, 1, 7'h10, 0, 0, 0, 0); step();
    apply(0, 1, 7'h00, 0, 0, 0, 0); step();
    idle(); #3;
    chk("push_count", int'(count), 94);
    step();

    // after 96 total pops the pushed preg is at the head
    repeat (93) begin apply(1, 0, 7'd0, 0, 0, 0, 0); step(); end
    idle(); #3;
    chk("wrap_preg_new", int'(preg_new), 16);
    chk("wrap_count", int'(count), 1);
    step();

    // drain to empty, then pop while empty
    apply(1, 0, 7'd0, 0, 0, 0, 0); step();
    apply(1, 0, 7'd0, 0, 0, 0, 0); step();
    idle(); #3;
    chk("empty_flag", int'(empty), 1);
    chk("empty_count", int'(count), 0);
    step();

    // push 0x05 into the empty list without a pop
    apply(0, 1, 7'h05, 0, 0, 0, 0); #3;
`ifdef FREE_LIST_BYPASS_EN
    chk("byp_valid_same", int'(preg_valid), 1);
    chk("byp_preg_same", int'(preg_new), 5);
`else
    chk("nobyp_valid_same", int'(preg_valid), 0);
`endif
    step();
    idle(); #3;
    chk("push_valid_next", int'(preg_valid), 1);
    chk("push_preg_next", int'(preg_new), 5);
    chk("push_count_next", int'(count), 1);
    step();
    apply(1, 0, 7'd0, 0, 0, 0, 0); step();

    // pop and push together at empty
    apply(1, 1, 7'h07, 0, 0, 0, 0); step();
    idle(); #3;
`ifdef FREE_LIST_BYPASS_EN
    chk("byp_take_count", int'(count), 0);
`else
    chk("nobyp_pp_count", int'(count), 1);
`endif
    step();

    // mispredict recovery
    do_reset();
    apply(1, 0, 7'd0, 0, 0, 1, 0); step();
    apply(1, 0, 7'd0, 0, 0, 1, 1); step();
    apply(1, 0, 7'd0, 0, 0, 1, 2); step();
    apply(0, 0, 7'd0, 1, 0, 0, 0); step();
    idle(); #3;
    chk("mp_preg_new", int'(preg_new), 33);
    chk("mp_count", int'(count), 95);
    step();

    // overflow: push at count 96, sticky until reset
    do_reset();
    apply(0, 1, 7'h05, 0, 0, 0, 0); step();
    idle(); #3;
    chk("ovf_set", int'(overflow_err), 1);
    step();
    repeat (3) begin idle(); step(); end
    apply(1, 0, 7'd0, 0, 0, 0, 0); #3;
    chk("ovf_held", int'(overflow_err), 1);
    // asynchronous reset mid-cycle
    #1 reset = 1'b1;
    #1;
    chk("async_rst_count", int'(count), 96);
    chk("async_rst_preg", int'(preg_new), 32);
    chk("async_rst_ovf", int'(overflow_err), 0);
    pop_en = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      int  cnt, mpt, tag;
      bit  pop, vr, mp, we;
      logic [6:0] po;
      cnt = m_tail - m_head;
      pop = bit'($urandom_range(0, 1));
      vr  = ($urandom_range(0, 2) == 0) && (cnt < 100);
      po  = 7'($urandom_range(0, 127));
      we  = bit'($urandom_range(0, 1));
      tag = $urandom_range(0, 15);
      mp  = 1'b0;
      mpt = $urandom_range(0, 15);
      if ($urandom_range(0, 11) == 0 && m_ck_ok[mpt] && (m_tail - m_ckpt[mpt]) <= 110)
        mp = 1'b1;
      apply(pop, vr, po, mp, mpt, we, tag);
      step();
    end
    idle(); step();
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Physical-register free list for the rename stage. It hands free physical registers (pregs) to rename and takes back `preg_old` from the ROB's retire port. On a branch mispredict it rewinds its allocation pointer to a per-ROB-tag checkpoint. It is the consumer end of the ROB retire/mispredict interface and the producer of `pd_new` for ROB allocation.

## Interface
Parameters:
- `NUM_PREGS`, 128: physical registers; 7-bit preg ids.
- `NUM_AREGS`, 32: architectural registers; pregs 0..31 are mapped at reset.
- `ROB_DEPTH`, 16: checkpoint slots, one per 5-bit ROB tag (tags 0..15).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `pop_en`  in  1: rename consumes the head preg this cycle (instruction has rd≠x0).
- `preg_new`  out  7: head preg offered to rename.
- `preg_valid`  out  1: `preg_new` is valid (list not empty, or bypass; see Configuration).
- `rob_write_en`  in  1: ROB allocation this cycle.
- `rob_tag`  in  5: ROB tail tag (`ptr`) being allocated.
- `valid_retired`  in  1: ROB retire pulse.
- `preg_old`  in  7: preg freed by retire.
- `mispredict`  in  1: flush younger than `mispredict_tag`.
- `mispredict_tag`  in  5: tag of the mispredicted branch.
- `empty`  out  1: free count is 0.
- `count`  out  8: number of free pregs.
- `overflow_err`  out  1: sticky; set by a push when `count == NUM_PREGS-NUM_AREGS`.

## Operation
- Storage is a circular FIFO of `NUM_PREGS` × 7-bit entries.
- `rd_ptr` and `wr_ptr` are 8 bits: a 7-bit index plus a wrap bit. `count = wr_ptr - rd_ptr` (mod 256).
- Reset state:
  - entries 0..95 hold pregs 32..127;
  - `rd_ptr = 0`, `wr_ptr = 96`;
  - `count = 96`, `empty = 0`, `preg_valid = 1`, `preg_new = 32`;
  - `overflow_err = 0`;
  - all checkpoints = 0.
- Pop:
  - `preg_new = mem[rd_ptr[6:0]]` (combinational read).
  - `pop_en && !empty && !mispredict` → `rd_ptr++` at the clock edge.
  - Pop while empty is ignored: no pointer change, no error.
- Push:
  - `valid_retired && preg_old != 0` → `mem[wr_ptr] <= preg_old`, `wr_ptr++`.
  - Preg 0 is never freed.
  - A push is still performed during a mispredict cycle.
- Checkpoint:
  - `rob_write_en && !mispredict` → `ckpt[rob_tag] <= rd_ptr_next`.
  - `rd_ptr_next` is the value after this cycle's pop, so the checkpoint includes the branch's own destination.
- Recovery:
  - `mispredict` → `rd_ptr <= ckpt[mispredict_tag]`.
  - Pregs popped by flushed instructions become free again without being re-pushed.
  - `wr_ptr` is untouched.
  - No overwrite hazard: live entries plus flushed-popped entries never exceed 96, which is less than 128.
- A mispredict on a tag never written since reset restores 0. Rename must not issue such a mispredict.

## Timing
- Pop, push, checkpoint and recovery all take effect at the same posedge. `count`, `empty` and `preg_new` reflect the result the next cycle.
- Simultaneous events:
  - pop + push: both apply; `count` unchanged.
  - mispredict + pop: pop dropped.
  - mispredict + push: both apply; `count = wr_ptr_next - ckpt`.
  - mispredict + `rob_write_en`: checkpoint write dropped.
- Assertion of `reset` at any time clears state immediately, including mid-operation.

## Configuration
- `FREE_LIST_BYPASS_EN` defined: when `empty && valid_retired && preg_old != 0`:
  - `preg_new = preg_old` and `preg_valid = 1` in the same cycle;
  - a `pop_en` in that cycle consumes it directly (no storage write, pointers unchanged).
- Not defined: `preg_valid = !empty`; a push into an empty list becomes visible the next cycle.

## Structure
- `types_pkg` holds:
  - `NUM_PREGS`, `NUM_AREGS`, `ROB_DEPTH`;
  - `typedef logic [6:0] preg_t`, `typedef logic [4:0] rob_tag_t`;
  - `typedef logic [7:0] fl_ptr_t`.
- One sub-module, `free_list_ckpt`: a 16 × 8-bit register file with one write port and one asynchronous read port, with asynchronous reset.

## Test plan
- Reset released → `preg_new = 32`, `count = 96`, `empty = 0`, `overflow_err = 0`.
- Pop 3 consecutive cycles → `preg_new` sequence 32, 33, 34; `count = 93`.
- Retire pushes `preg_old = 0x10`, then `preg_old = 0` → `count` rises by 1 only; after 96 total pops, `preg_new = 0x10`.
- Mispredict recovery:
  - Alloc tag 0 with a pop (gets 32).
  - Alloc tags 1–2 with pops (get 33, 34).
  - Mispredict at tag 0 → next `preg_new = 33`, `count = 95`.
- Pop 96 times → `empty = 1`. A further `pop_en` leaves `count = 0`. A retire push of `0x05` with no pop:
  - without `FREE_LIST_BYPASS_EN`: `preg_valid` rises next cycle;
  - with it: same cycle.
- Extra retire push at `count = 96` → `overflow_err = 1`, held until `reset`.
